// File: rtl/seq4_pkg.sv
// seq4_pkg
// Shared definitions for the 4-word sequence sort collector:
//   - state_t   : collector FSM states (COLLECT, SORT1, SORT2, SORT3, EMIT)
//   - FRAME_LEN : number of words in one frame
//   - IDX_W     : width of the beat / emit index
// Build option SEQ4_SORT_DESCENDING_EN is consumed by seq4_cmp_swap and
// seq4_sort_collector, not by this package.
package seq4_pkg;

  localparam int FRAME_LEN = 4;
  localparam int IDX_W     = 2;

  typedef enum logic [2:0] {
    COLLECT,
    SORT1,
    SORT2,
    SORT3,
    EMIT
  } state_t;

endpackage

// File: rtl/seq4_cmp_swap.sv
// seq4_cmp_swap
// Combinational compare-exchange of two unsigned DW-bit words.
// Ports:
//   i_x, i_y       : words at the lower / higher slot index
//   o_first        : word that belongs at the lower slot index
//   o_second       : word that belongs at the higher slot index
// Build option SEQ4_SORT_DESCENDING_EN: when defined the larger word goes to
// the lower index (descending); otherwise the smaller word does (ascending).
// Equal words are never swapped, which keeps duplicates in arrival order.
module seq4_cmp_swap #(
  parameter int DW = 3
) (
  input  logic [DW-1:0] i_x,
  input  logic [DW-1:0] i_y,
  output logic [DW-1:0] o_first,
  output logic [DW-1:0] o_second
);

  logic w_swap;

  // Strict comparison only, so a tie leaves the pair in place.
  always_comb begin
`ifdef SEQ4_SORT_DESCENDING_EN
    w_swap = (i_x < i_y);
`else
    w_swap = (i_x > i_y);
`endif
    o_first  = w_swap ? i_y : i_x;
    o_second = w_swap ? i_x : i_y;
  end

endmodule

// File: rtl/seq4_sort_collector.sv
// seq4_sort_collector
// Collects a 4-word frame from the sequence stream, sorts it with a
// three-stage compare-exchange network and re-emits it serially with its own
// frame strobe, while publishing the frame maximum.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : input beat valid
//   in_ready   : block can accept a beat (only while collecting)
//   inp        : input word (unsigned, DW bits)
//   in_last    : frame strobe, expected on the 4th beat
//   out_valid  : outp carries a sorted word
//   outp       : sorted output word (holds when out_valid is low)
//   out_last   : high with the 4th sorted word
//   max        : largest word of the most recent completed frame
//   frame_err  : one-cycle pulse after a framing violation
// Build option SEQ4_SORT_DESCENDING_EN: sort descending and take max from
// slot 0; default build sorts ascending and takes max from slot 3.
module seq4_sort_collector
  import seq4_pkg::*;
#(
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] inp,
  input  logic          in_last,
  output logic          out_valid,
  output logic [DW-1:0] outp,
  output logic          out_last,
  output logic [DW-1:0] max,
  output logic          frame_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t r_state;
  state_t w_next_state;

  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_e;
  logic [DW-1:0]    r_slot [FRAME_LEN];

  logic          r_out_valid;
  logic [DW-1:0] r_outp;
  logic          r_out_last;
  logic [DW-1:0] r_max;
  logic          r_frame_err;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_idx_last;
  logic          w_good_end;
  logic          w_bad_frame;
  logic          w_emit;

  logic [DW-1:0] w_a_x, w_a_y, w_a_first, w_a_second;
  logic [DW-1:0] w_b_x, w_b_y, w_b_first, w_b_second;
  logic [DW-1:0] w_c_first, w_c_second;

  // A frame is good only if the strobe lands exactly on the 4th beat; a strobe
  // that is early, or missing on the 4th beat, is a framing violation.
  assign w_accept    = in_valid & w_in_ready;
  assign w_idx_last  = (r_idx == LAST_IDX);
  assign w_good_end  = w_accept & w_idx_last & in_last;
  assign w_bad_frame = w_accept & (w_idx_last ^ in_last);

  // Units A and B are shared between SORT1 and SORT2; unit C does SORT3.
  seq4_cmp_swap #(.DW(DW)) u_cmp_a (
    .i_x      (w_a_x),
    .i_y      (w_a_y),
    .o_first  (w_a_first),
    .o_second (w_a_second)
  );

  seq4_cmp_swap #(.DW(DW)) u_cmp_b (
    .i_x      (w_b_x),
    .i_y      (w_b_y),
    .o_first  (w_b_first),
    .o_second (w_b_second)
  );

  seq4_cmp_swap #(.DW(DW)) u_cmp_c (
    .i_x      (r_slot[1]),
    .i_y      (r_slot[2]),
    .o_first  (w_c_first),
    .o_second (w_c_second)
  );

  // State register: reset always returns to COLLECT, dropping any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. EMIT lingers for one extra cycle while the registered
  // 4th word (with out_last) is on the outputs, so the next frame's first beat
  // is accepted only in the cycle after out_last.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      COLLECT: if (w_good_end) w_next_state = SORT1;
      SORT1:   w_next_state = SORT2;
      SORT2:   w_next_state = SORT3;
      SORT3:   w_next_state = EMIT;
      EMIT:    if (r_out_last) w_next_state = COLLECT;
      default: w_next_state = COLLECT;
    endcase
  end

  // Output/control decode: handshake, emit strobe, and the operand routing
  // that lets units A/B serve both the (0,1)(2,3) and (0,2)(1,3) stages.
  always_comb begin
    w_in_ready = (r_state == COLLECT);
    w_emit     = (r_state == EMIT) && !r_out_last;
    w_a_x      = r_slot[0];
    w_a_y      = r_slot[1];
    w_b_x      = r_slot[2];
    w_b_y      = r_slot[3];
    if (r_state == SORT2) begin
      w_a_y = r_slot[2];
      w_b_x = r_slot[1];
    end
  end

  // Datapath: slot capture, in-place sorting, max capture and the registered
  // serial output stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_e         <= '0;
      r_out_valid <= 1'b0;
      r_outp      <= '0;
      r_out_last  <= 1'b0;
      r_max       <= '0;
      r_frame_err <= 1'b0;
      for (int k = 0; k < FRAME_LEN; k++) begin
        r_slot[k] <= '0;
      end
    end else begin
      r_frame_err <= w_bad_frame;
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_slot[r_idx] <= inp;
            r_idx <= (w_idx_last || in_last) ? '0 : r_idx + 1'b1;
          end
        end
        SORT1: begin
          r_slot[0] <= w_a_first;
          r_slot[1] <= w_a_second;
          r_slot[2] <= w_b_first;
          r_slot[3] <= w_b_second;
        end
        SORT2: begin
          r_slot[0] <= w_a_first;
          r_slot[2] <= w_a_second;
          r_slot[1] <= w_b_first;
          r_slot[3] <= w_b_second;
        end
        SORT3: begin
          r_slot[1] <= w_c_first;
          r_slot[2] <= w_c_second;
`ifdef SEQ4_SORT_DESCENDING_EN
          r_max <= r_slot[0];
`else
          r_max <= r_slot[3];
`endif
          r_e <= '0;
        end
        EMIT: begin
          if (w_emit) begin
            r_out_valid <= 1'b1;
            r_outp      <= r_slot[r_e];
            r_out_last  <= (r_e == LAST_IDX);
            r_e         <= r_e + 1'b1;
          end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign outp      = r_outp;
  assign out_last  = r_out_last;
  assign max       = r_max;
  assign frame_err = r_frame_err;

endmodule

// File: doc/seq4_sort_collector.md
Name: seq4_sort_collector

Overview:
Receive end of the 4-word framed sequence stream. The stream producer drives one word per valid beat and a frame strobe on the 4th word of each frame. This block collects a frame and sorts it with a 3-stage compare-exchange network. It then re-emits the frame serially in sorted order with its own frame strobe, and reports the frame maximum. It sits downstream of the sequence stimulus generator, in place of or alongside the compare block.

Parameters:
DW, 3, word width in bits of inp, outp and max (unsigned)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  inp and in_last are valid this cycle
in_ready  output  1  block can accept a beat; beat accepted when in_valid and in_ready both high
inp  input  DW  input word (unsigned)
in_last  input  1  frame strobe; high on the 4th beat of a frame
out_valid  output  1  outp is a sorted word
outp  output  DW  sorted output word
out_last  output  1  high with the 4th sorted word
max  output  DW  largest word of the most recent completed frame
frame_err  output  1  one-cycle pulse on a framing violation

Behaviour:
- Reset values: in_ready=1, out_valid=0, outp=0, out_last=0, max=0, frame_err=0, beat index=0, state=COLLECT.
- Reset asserted in any state, including mid-SORT or mid-EMIT, discards the frame in progress on that edge.
- States and transitions:
  - COLLECT: in_ready=1. Each accepted beat is written to slot[idx], then idx increments.
  - Accepted beat with idx=3 and in_last=1: go to SORT1, idx=0.
  - Accepted beat with idx<3 and in_last=1: frame_err pulses next cycle, beat discarded, idx=0, stay in COLLECT.
  - Accepted beat with idx=3 and in_last=0: frame_err pulses next cycle, frame discarded, idx=0, stay in COLLECT.
  - SORT1: compare-exchange (0,1) and (2,3).
  - SORT2: compare-exchange (0,2) and (1,3).
  - SORT3: compare-exchange (1,2). max is loaded with slot[3] as it stands after this stage. Go to EMIT, e=0.
  - EMIT: out_valid=1, outp=slot[e], out_last=(e==3). e increments each cycle. After e=3, return to COLLECT.
- in_ready=0 in SORT1, SORT2, SORT3 and EMIT. in_valid is ignored and no data is lost.
- Outputs are registered. With the 4th beat accepted at edge T, out_valid is high in the four cycles after edge T+4. The first word can be accepted in the cycle after out_last.
- No output backpressure. The consumer must take one word per cycle while out_valid=1.
- Comparisons are unsigned. Equal words are not swapped, so sorting is stable for duplicates.
- outp holds its last value when out_valid=0. frame_err is never asserted in the same cycle as out_valid.

Optional Feature:
SEQ4_SORT_DESCENDING_EN
- Defined: every compare-exchange puts the larger word at the lower index. Frames are emitted in descending order, and max is loaded from slot[0] after SORT3.
- Undefined: ascending order, as described above.
- Latency, handshake and framing rules are identical in both cases.

Decomposition:
- Shared package seq4_pkg: state enum (COLLECT, SORT1, SORT2, SORT3, EMIT), FRAME_LEN=4, index width constant (2 bits).
- One sub-module, seq4_cmp_swap: a combinational compare-exchange on two DW-bit words, with ascending/descending selected by the macro.
- The block instantiates seq4_cmp_swap three times: two units are shared for SORT1 and SORT2, one unit is used in SORT3.

Test Plan:
- DW=3, frame 5,2,7,1 with in_last on the 4th beat -> outp 1,2,5,7 in the four cycles after edge T+4, out_last on 7, max=7.
- Frame 3,3,0,3 -> outp 0,3,3,3, max=3. Then frame 6,6,6,6 -> 6,6,6,6, max=6.
- in_last on the 2nd beat (4,1) -> frame_err pulses once, no out_valid. A following clean frame 2,0,1,3 -> 0,1,2,3.
- in_valid held high during SORT and EMIT with values 7,7,7 -> in_ready=0, the values are ignored, and the next frame starts at slot 0.
- rst pulsed on the 2nd EMIT cycle of frame 5,2,7,1 -> from the next cycle out_valid=0 and max=0, then a new frame sorts correctly.
- With SEQ4_SORT_DESCENDING_EN defined, frame 5,2,7,1 -> outp 7,5,2,1, max=7.
